// File: rtl/v_issue_sched.sv
// In-order single-issue scheduler feeding VALU/VRED/VSLDU/VLSU from one issue register.
// Per-unit scoreboard entries track occupancy, the pending write and the source-register set.

module v_issue_sb_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_set,
  input  logic        i_done,
  input  logic        i_wr,
  input  logic [4:0]  i_wreg,
  input  logic [31:0] i_rmask,
  output logic        o_occ,
  output logic        o_wr,
  output logic [4:0]  o_wreg,
  output logic [31:0] o_rmask
);
  logic        r_occ, r_wr;
  logic [4:0]  r_wreg;
  logic [31:0] r_rmask;

  // set only fires when the unit is free, so set and a valid done never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= 1'b0;
      r_wr    <= 1'b0;
      r_wreg  <= '0;
      r_rmask <= '0;
    end else if (i_set) begin
      r_occ   <= 1'b1;
      r_wr    <= i_wr;
      r_wreg  <= i_wreg;
      r_rmask <= i_rmask;
    end else if (i_done && r_occ) begin
      r_occ   <= 1'b0;
      r_wr    <= 1'b0;
      r_rmask <= '0;
    end
  end

  assign o_occ   = r_occ;
  assign o_wr    = r_wr;
  assign o_wreg  = r_wreg;
  assign o_rmask = r_rmask;
endmodule

module v_issue_sched #(
  parameter int VLEN = 256,
  parameter int VL_W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_unit,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_vd,
  input  logic [4:0]      in_vs1,
  input  logic [4:0]      in_vs2,
  input  logic            in_wr_vd,
  input  logic            in_rd_vd,
  input  logic            in_rd_vs1,
  input  logic            in_rd_vs2,
  input  logic [1:0]      in_vsew,
  input  logic [VL_W-1:0] in_vl,
  output logic [3:0]      iss_valid,
  input  logic [3:0]      iss_ready,
  output logic [3:0]      iss_op,
  output logic [4:0]      iss_vd,
  output logic [4:0]      iss_vs1,
  output logic [4:0]      iss_vs2,
  output logic [1:0]      iss_vsew,
  output logic [VL_W-1:0] iss_vl,
  input  logic [3:0]      done,
  output logic            illegal,
  output logic            busy
);
  localparam int NUM_UNITS = 4;

  typedef struct packed {
    logic [1:0]      unit;
    logic [3:0]      op;
    logic [4:0]      vd, vs1, vs2;
    logic            wr_vd, rd_vd, rd_vs1, rd_vs2;
    logic [1:0]      vsew;
    logic [VL_W-1:0] vl;
  } instr_t;

  instr_t r_ir;
  logic   r_ir_valid, r_illegal;
  instr_t w_in;
  logic [VL_W-1:0] w_vlmax;
  logic [3:0]      w_opmax;
  logic            w_in_illegal, w_accept, w_load, w_fire, w_hazard;
  logic [31:0]     w_src;
  logic [NUM_UNITS-1:0]       w_occ, w_wr;
  logic [NUM_UNITS-1:0][4:0]  w_wreg;
  logic [NUM_UNITS-1:0][31:0] w_rmask;

  assign w_in = '{unit: in_unit, op: in_op, vd: in_vd, vs1: in_vs1, vs2: in_vs2,
                  wr_vd: in_wr_vd, rd_vd: in_rd_vd, rd_vs1: in_rd_vs1, rd_vs2: in_rd_vs2,
                  vsew: in_vsew, vl: in_vl};

  always_comb begin
    case (in_vsew)
      2'd0:    w_vlmax = VL_W'(VLEN / 8);
      2'd1:    w_vlmax = VL_W'(VLEN / 16);
      2'd2:    w_vlmax = VL_W'(VLEN / 32);
      default: w_vlmax = '0;
    endcase
    case (in_unit)
      2'd0:    w_opmax = 4'd10;
      2'd1:    w_opmax = 4'd2;
      2'd2:    w_opmax = 4'd5;
      default: w_opmax = 4'd12;
    endcase
  end

  assign w_in_illegal = (in_vsew == 2'd3) | (in_op == 4'd0) | (in_op > w_opmax) | (in_vl > w_vlmax);
  assign in_ready     = !rst & (!r_ir_valid | w_fire);
  assign w_accept     = in_valid & in_ready;
  assign w_load       = w_accept & !w_in_illegal & (in_vl != '0);

  // source set of the held instruction as a 32-bit register mask
  assign w_src = ({31'b0, r_ir.rd_vs1} << r_ir.vs1)
               | ({31'b0, r_ir.rd_vs2} << r_ir.vs2)
               | ({31'b0, r_ir.rd_vd}  << r_ir.vd);

  always_comb begin
    w_hazard = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (w_occ[u]) begin
        if (w_wr[u] && w_src[w_wreg[u]]) w_hazard = 1'b1;
        if (r_ir.wr_vd && ((w_wr[u] && (w_wreg[u] == r_ir.vd)) || w_rmask[u][r_ir.vd]))
          w_hazard = 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_UNITS; g++) begin : g_unit
      assign iss_valid[g] = !rst & r_ir_valid & (r_ir.unit == 2'(g)) & !w_occ[g] & !w_hazard;
      v_issue_sb_entry u_sb (
        .clk     (clk),
        .rst     (rst),
        .i_set   (iss_valid[g] & iss_ready[g]),
        .i_done  (done[g]),
        .i_wr    (r_ir.wr_vd),
        .i_wreg  (r_ir.vd),
        .i_rmask (w_src),
        .o_occ   (w_occ[g]),
        .o_wr    (w_wr[g]),
        .o_wreg  (w_wreg[g]),
        .o_rmask (w_rmask[g])
      );
    end
  endgenerate

  assign w_fire = |(iss_valid & iss_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_ir       <= '0;
    end else begin
      r_illegal <= w_accept & w_in_illegal;
      if (w_load) begin
        r_ir_valid <= 1'b1;
        r_ir       <= w_in;
      end else if (w_fire) begin
        r_ir_valid <= 1'b0;
      end
    end
  end

  assign iss_op   = r_ir.op;
  assign iss_vd   = r_ir.vd;
  assign iss_vs1  = r_ir.vs1;
  assign iss_vs2  = r_ir.vs2;
  assign iss_vsew = r_ir.vsew;
  assign iss_vl   = r_ir.vl;
  assign illegal  = r_illegal;
  assign busy     = r_ir_valid | (|w_occ);
endmodule

// File: tb/tb_v_issue_sched.sv
// Randomized bench for v_issue_sched against a cycle-level instruction model.
module tb_v_issue_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_ready;
  logic [1:0] in_unit = 0;
  logic [3:0] in_op = 0;
  logic [4:0] in_vd = 0, in_vs1 = 0, in_vs2 = 0;
  logic in_wr_vd = 0, in_rd_vd = 0, in_rd_vs1 = 0, in_rd_vs2 = 0;
  logic [1:0] in_vsew = 0;
  logic [8:0] in_vl = 0;
  logic [3:0] iss_valid, iss_ready = 0, iss_op, done = 0;
  logic [4:0] iss_vd, iss_vs1, iss_vs2;
  logic [1:0] iss_vsew;
  logic [8:0] iss_vl;
  logic illegal, busy;

  always #5 clk = ~clk;

  v_issue_sched #(.VLEN(256), .VL_W(9)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_op(in_op), .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_wr_vd(in_wr_vd),
    .in_rd_vd(in_rd_vd), .in_rd_vs1(in_rd_vs1), .in_rd_vs2(in_rd_vs2), .in_vsew(in_vsew),
    .in_vl(in_vl), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vd(iss_vd), .iss_vs1(iss_vs1), .iss_vs2(iss_vs2), .iss_vsew(iss_vsew),
    .iss_vl(iss_vl), .done(done), .illegal(illegal), .busy(busy)
  );

  typedef struct {
    int unit, op, vd, vs1, vs2, vsew, vl;
    bit wr_vd, rd_vd, rd_vs1, rd_vs2;
  } ins_t;

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int opmax(int unit);
    case (unit)
      0: return 10;
      1: return 2;
      2: return 5;
      default: return 12;
    endcase
  endfunction

  function automatic int vlmax(int vsew);
    return (vsew < 3) ? 256 / (8 << vsew) : 0;
  endfunction

  function automatic bit legal(ins_t i);
    return i.vsew != 3 && i.op != 0 && i.op <= opmax(i.unit) && i.vl <= vlmax(i.vsew);
  endfunction

  function automatic bit reads(ins_t i, int r);
    return (i.rd_vs1 && i.vs1 == r) || (i.rd_vs2 && i.vs2 == r) || (i.rd_vd && i.vd == r);
  endfunction

  // model state: held instruction and the instruction each unit is still executing
  ins_t m_ir, m_pend[4];
  bit   m_irv = 0, m_ill = 0;
  bit   m_occ[4] = '{0, 0, 0, 0};

  function automatic bit hazard();
    for (int u = 0; u < 4; u++) begin
      if (m_occ[u]) begin
        if (m_pend[u].wr_vd && reads(m_ir, m_pend[u].vd)) return 1;
        if (m_ir.wr_vd && m_pend[u].wr_vd && m_pend[u].vd == m_ir.vd) return 1;
        if (m_ir.wr_vd && reads(m_pend[u], m_ir.vd)) return 1;
      end
    end
    return 0;
  endfunction

  task automatic gen(output ins_t i);
    int k;
    i.unit = $urandom_range(0, 3);
    k = $urandom_range(0, 9);
    i.op = (k == 0) ? 0 : (k == 1) ? opmax(i.unit) + 1 : (k == 2) ? $urandom_range(0, 15)
         : $urandom_range(1, opmax(i.unit));
    i.vsew = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
    k = $urandom_range(0, 9);
    if (i.vsew == 3) i.vl = $urandom_range(0, 40);
    else if (k == 0) i.vl = 0;
    else if (k == 1) i.vl = vlmax(i.vsew) + 1;
    else if (k == 2) i.vl = vlmax(i.vsew);
    else i.vl = $urandom_range(1, vlmax(i.vsew));
    i.vd = $urandom_range(0, 7);
    i.vs1 = $urandom_range(0, 7);
    i.vs2 = $urandom_range(0, 7);
    i.wr_vd = $urandom_range(0, 3) != 0;
    i.rd_vd = $urandom_range(0, 3) == 0;
    i.rd_vs1 = $urandom_range(0, 1);
    i.rd_vs2 = $urandom_range(0, 1);
  endtask

  initial begin
    ins_t ni;
    logic [3:0] e_issv;
    bit e_fire, e_rdy;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      cyc = c;
      rst = (c == 0) || ($urandom_range(0, 149) == 0);
      gen(ni);
      in_valid  = $urandom_range(0, 3) != 0;
      in_unit   = 2'(ni.unit);
      in_op     = 4'(ni.op);
      in_vd     = 5'(ni.vd);
      in_vs1    = 5'(ni.vs1);
      in_vs2    = 5'(ni.vs2);
      in_wr_vd  = ni.wr_vd;
      in_rd_vd  = ni.rd_vd;
      in_rd_vs1 = ni.rd_vs1;
      in_rd_vs2 = ni.rd_vs2;
      in_vsew   = 2'(ni.vsew);
      in_vl     = 9'(ni.vl);
      for (int u = 0; u < 4; u++) begin
        iss_ready[u] = $urandom_range(0, 3) != 0;
        done[u]      = $urandom_range(0, 3) == 0;
      end

      @(negedge clk);
      e_issv = '0;
      if (!rst && m_irv && !m_occ[m_ir.unit] && !hazard()) e_issv[m_ir.unit] = 1'b1;
      e_fire = |(e_issv & iss_ready);
      e_rdy  = !rst && (!m_irv || e_fire);
      chk("in_ready", 64'(in_ready), 64'(e_rdy));
      chk("iss_valid", 64'(iss_valid), 64'(e_issv));
      chk("illegal", 64'(illegal), 64'(m_ill));
      chk("busy", 64'(busy), 64'(m_irv || m_occ[0] || m_occ[1] || m_occ[2] || m_occ[3]));
      if (m_irv) begin
        chk("iss_op", 64'(iss_op), 64'(m_ir.op));
        chk("iss_vd", 64'(iss_vd), 64'(m_ir.vd));
        chk("iss_vs1", 64'(iss_vs1), 64'(m_ir.vs1));
        chk("iss_vs2", 64'(iss_vs2), 64'(m_ir.vs2));
        chk("iss_vsew", 64'(iss_vsew), 64'(m_ir.vsew));
        chk("iss_vl", 64'(iss_vl), 64'(m_ir.vl));
      end

      @(posedge clk);
      if (rst) begin
        m_irv = 0;
        m_ill = 0;
        for (int u = 0; u < 4; u++) m_occ[u] = 0;
      end else begin
        for (int u = 0; u < 4; u++) if (done[u]) m_occ[u] = 0;
        if (e_fire) begin
          m_occ[m_ir.unit]  = 1;
          m_pend[m_ir.unit] = m_ir;
        end
        m_ill = in_valid && e_rdy && !legal(ni);
        if (in_valid && e_rdy && legal(ni) && ni.vl != 0) begin
          m_ir  = ni;
          m_irv = 1;
        end else if (e_fire) begin
          m_irv = 0;
        end
      end
      #1;
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
